redpitaya_pll_drp_ctrl: RTL and testbench
=========================================

REDPITAYA_PLL_DRP_CTRL -- requirements
Module: redpitaya_pll_drp_ctrl

Interface
REQ-001 Parameter LOCK_TIMEOUT, default 65535, adc_clk cycles allowed for LOCKED after PLL reset release.
REQ-002 Parameter DRDY_TIMEOUT, default 63, adc_clk cycles allowed for DRDY after each DEN.
REQ-003 Parameter RST_HOLD, default 15, adc_clk cycles the PLL RST stays high before DRP access begins.
REQ-004 adc_clk_i  in  1  sole clock; also drives PLL DCLK externally.
REQ-005 adc_rst_i  in  1  reset, synchronous, active-high.
REQ-006 req_i  in  1  single-cycle request to reprogram the serial clock output (CLKOUT3).
REQ-007 sel_i  in  1  divider choice, sampled when req_i is accepted: 0 = divide 4 (250 MHz), 1 = divide 2 (500 MHz).
REQ-008 pll_locked_i  in  1  PLL LOCKED.
REQ-009 drp_do_i  in  16  DRP read data.
REQ-010 drp_drdy_i  in  1  DRP ready.
REQ-011 pll_rst_o  out  1  PLL RST.
REQ-012 drp_daddr_o  out  7  DRP address.
REQ-013 drp_di_o  out  16  DRP write data.
REQ-014 drp_den_o  out  1  DRP enable, single-cycle.
REQ-015 drp_dwe_o  out  1  DRP write enable, single-cycle, only together with DEN.
REQ-016 busy_o  out  1  sequence in progress.
REQ-017 done_o  out  1  single-cycle pulse on successful relock.
REQ-018 err_o  out  1  sticky timeout flag.
REQ-019 dsp_rst_o  out  1  downstream datapath reset, high whenever the PLL is unlocked or being reprogrammed.

Function
REQ-020 States: IDLE, HOLD_RST, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT, RELEASE, WAIT_LOCK, ERROR.
REQ-021 IDLE: req_i high -> latch sel_i, set busy_o, go HOLD_RST next cycle; req_i ignored in every other state.
REQ-022 HOLD_RST: pll_rst_o high; after RST_HOLD+1 cycles go RD_REQ with entry index 0.
REQ-023 Register table: entry 0 = address 0x0E (ClkReg1), keep mask 0xF000, field high_time[11:6]/low_time[5:0] = 2/2 (div 4) or 1/1 (div 2); entry 1 = address 0x0F (ClkReg2), keep mask 0xFF3F, field 0x0000.
REQ-024 RD_REQ: one cycle with drp_den_o=1, drp_dwe_o=0, drp_daddr_o = entry address; go RD_WAIT.
REQ-025 RD_WAIT: on drp_drdy_i capture drp_do_i; go WR_REQ.
REQ-026 WR_REQ: one cycle with drp_den_o=1, drp_dwe_o=1, drp_di_o = (captured & keep) | field; go WR_WAIT.
REQ-027 WR_WAIT: on drp_drdy_i, entry 0 -> RD_REQ for entry 1; entry 1 -> RELEASE.
REQ-028 Only one DRP transaction outstanding; DEN never reasserted before DRDY of the previous access.
REQ-029 drp_drdy_i outside RD_WAIT/WR_WAIT is ignored.
REQ-030 RD_WAIT/WR_WAIT: DRDY counter exceeds DRDY_TIMEOUT -> ERROR.
REQ-031 RELEASE: pll_rst_o low for this and all later states; go WAIT_LOCK.
REQ-032 WAIT_LOCK: pll_locked_i high -> done_o pulse, busy_o low, IDLE; counter exceeds LOCK_TIMEOUT -> ERROR.
REQ-033 ERROR: err_o=1, pll_rst_o=0, busy_o=0; returns to IDLE next cycle; err_o clears on the next accepted req_i.
REQ-034 Counters saturate-free: 16-bit, cleared on each state entry.
REQ-035 dsp_rst_o = busy_o OR NOT pll_locked_i, registered (one-cycle latency).
REQ-036 drp_daddr_o/drp_di_o hold their last value when DEN is low.

Reset
REQ-037 adc_rst_i high on any clock edge -> IDLE, all counters 0, pll_rst_o=1 for that cycle, drp_den_o=0, drp_dwe_o=0, busy_o=0, done_o=0, err_o=0, dsp_rst_o=1, drp_daddr_o=0, drp_di_o=0.
REQ-038 Reset mid-transaction abandons the DRP access; no DEN issued until a new req_i.

Structure
REQ-039 Shared package holds: state encoding, DRP addresses 0x0E/0x0F, keep masks, divider field constants.
REQ-040 One sub-module natural: redpitaya_drp_access (single DRP read/write with DRDY timeout), instanced once.

Verification
REQ-041 req_i, sel_i=1, DRDY 3 cycles after each DEN, DO=0xA0C3/0x1480 -> writes 0xA041 to 0x0E, 0x1400 to 0x0F; lock after 100 cycles -> done_o pulse.
REQ-042 sel_i=0, DO=0x0000 both -> writes 0x0082, 0x0000; pll_rst_o high exactly RST_HOLD+1 cycles before first DEN.
REQ-043 DRDY never returned -> err_o=1 after DRDY_TIMEOUT+1 cycles, pll_rst_o=0, busy_o=0.
REQ-044 LOCK_TIMEOUT=100, locked held low -> err_o after 101 cycles in WAIT_LOCK; next req_i clears err_o.
REQ-045 adc_rst_i during WR_WAIT -> IDLE next cycle, no further DEN; req_i during busy ignored (exactly 4 DEN pulses per sequence).

Source files
------------

// File: rtl/redpitaya_pll_drp_ctrl_pkg.sv
// Shared definitions for the PLL CLKOUT3 reprogramming controller:
// FSM encoding, DRP register addresses, keep masks and divider fields.
package redpitaya_pll_drp_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HOLD_RST  = 4'd1,
        ST_RD_REQ    = 4'd2,
        ST_RD_WAIT   = 4'd3,
        ST_WR_REQ    = 4'd4,
        ST_WR_WAIT   = 4'd5,
        ST_RELEASE   = 4'd6,
        ST_WAIT_LOCK = 4'd7,
        ST_ERROR     = 4'd8
    } state_t;

    localparam logic [6:0]  DRP_ADDR_CLKREG1 = 7'h0E;
    localparam logic [6:0]  DRP_ADDR_CLKREG2 = 7'h0F;
    localparam logic [15:0] KEEP_CLKREG1     = 16'hF000;
    localparam logic [15:0] KEEP_CLKREG2     = 16'hFF3F;
    // ClkReg1 field: high_time[11:6], low_time[5:0]
    localparam logic [15:0] FIELD_DIV4       = {4'h0, 6'd2, 6'd2};
    localparam logic [15:0] FIELD_DIV2       = {4'h0, 6'd1, 6'd1};
    localparam logic [15:0] FIELD_CLKREG2    = 16'h0000;

    function automatic logic [6:0] entry_addr(input logic idx);
        return idx ? DRP_ADDR_CLKREG2 : DRP_ADDR_CLKREG1;
    endfunction

    function automatic logic [15:0] entry_wdata(input logic idx, input logic sel,
                                                input logic [15:0] rdata);
        logic [15:0] keep;
        logic [15:0] field;
        keep  = idx ? KEEP_CLKREG2 : KEEP_CLKREG1;
        field = idx ? FIELD_CLKREG2 : (sel ? FIELD_DIV2 : FIELD_DIV4);
        return (rdata & keep) | field;
    endfunction

endpackage

// File: rtl/redpitaya_drp_access.sv
// Single DRP read or write: registered DEN/DWE/address/data, then a bounded
// wait for DRDY. Only one access may be outstanding at a time.
module redpitaya_drp_access #(
    parameter int DRDY_TIMEOUT = 63
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_we,
    input  logic [6:0]  i_addr,
    input  logic [15:0] i_di,
    input  logic [15:0] i_drp_do,
    input  logic        i_drp_drdy,
    output logic [6:0]  o_drp_daddr,
    output logic [15:0] o_drp_di,
    output logic        o_drp_den,
    output logic        o_drp_dwe,
    output logic        o_done,
    output logic        o_timeout,
    output logic [15:0] o_rdata
);

    logic        r_den;
    logic        r_dwe;
    logic        r_pend;
    logic [6:0]  r_addr;
    logic [15:0] r_di;
    logic [15:0] r_rdata;
    logic [15:0] r_cnt;
    logic        w_done;
    logic        w_timeout;
    logic        w_issue;

    assign w_done    = r_pend & i_drp_drdy;
    assign w_timeout = r_pend & ~i_drp_drdy & (r_cnt == 16'(DRDY_TIMEOUT));
    // A new access may start in the same cycle the previous one completes.
    assign w_issue   = i_start & ~r_den & (~r_pend | w_done);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_den   <= 1'b0;
            r_dwe   <= 1'b0;
            r_pend  <= 1'b0;
            r_addr  <= '0;
            r_di    <= '0;
            r_rdata <= '0;
            r_cnt   <= '0;
        end else begin
            r_den <= w_issue;
            r_dwe <= w_issue & i_we;
            if (w_issue) begin
                r_addr <= i_addr;
            end
            if (w_issue && i_we) begin
                r_di <= i_di;
            end
            if (r_den) begin
                r_pend <= 1'b1;
                r_cnt  <= '0;
            end else if (w_done || w_timeout) begin
                r_pend <= 1'b0;
            end else if (r_pend) begin
                r_cnt <= r_cnt + 16'd1;
            end
            if (w_done) begin
                r_rdata <= i_drp_do;
            end
        end
    end

    assign o_drp_daddr = r_addr;
    assign o_drp_di    = r_di;
    assign o_drp_den   = r_den;
    assign o_drp_dwe   = r_dwe;
    assign o_done      = w_done;
    assign o_timeout   = w_timeout;
    // Bypass so the write data can be formed in the cycle DRDY arrives.
    assign o_rdata     = w_done ? i_drp_do : r_rdata;

endmodule

// File: rtl/redpitaya_pll_drp_ctrl.sv
// Reprograms the PLL CLKOUT3 divider over DRP: hold PLL reset, read-modify-write
// ClkReg1/ClkReg2, release reset and wait for LOCKED.
module redpitaya_pll_drp_ctrl
    import redpitaya_pll_drp_ctrl_pkg::*;
#(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int DRDY_TIMEOUT = 63,
    parameter int RST_HOLD     = 15
) (
    input  logic        adc_clk_i,
    input  logic        adc_rst_i,
    input  logic        req_i,
    input  logic        sel_i,
    input  logic        pll_locked_i,
    input  logic [15:0] drp_do_i,
    input  logic        drp_drdy_i,
    output logic        pll_rst_o,
    output logic [6:0]  drp_daddr_o,
    output logic [15:0] drp_di_o,
    output logic        drp_den_o,
    output logic        drp_dwe_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic        dsp_rst_o
);

    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_cnt;
    logic        r_sel;
    logic        r_idx;
    logic        w_idx_next;
    logic        r_err;
    logic        r_done;
    logic        r_pll_rst;
    logic        r_dsp_rst;
    logic        w_busy;
    logic        w_start;
    logic        w_we;
    logic        w_acc_done;
    logic        w_acc_timeout;
    logic [15:0] w_rdata;
    logic        w_hold_next;

    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        case (r_state)
            ST_IDLE:      if (req_i) w_state_next = ST_HOLD_RST;
            ST_HOLD_RST: begin
                if (r_cnt == 16'(RST_HOLD)) begin
                    w_state_next = ST_RD_REQ;
                    w_idx_next   = 1'b0;
                end
            end
            ST_RD_REQ:    w_state_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (w_acc_done)         w_state_next = ST_WR_REQ;
                else if (w_acc_timeout) w_state_next = ST_ERROR;
            end
            ST_WR_REQ:    w_state_next = ST_WR_WAIT;
            ST_WR_WAIT: begin
                if (w_acc_done) begin
                    if (!r_idx) begin
                        w_state_next = ST_RD_REQ;
                        w_idx_next   = 1'b1;
                    end else begin
                        w_state_next = ST_RELEASE;
                    end
                end else if (w_acc_timeout) begin
                    w_state_next = ST_ERROR;
                end
            end
            ST_RELEASE:   w_state_next = ST_WAIT_LOCK;
            ST_WAIT_LOCK: begin
                if (pll_locked_i)                         w_state_next = ST_IDLE;
                else if (r_cnt == 16'(LOCK_TIMEOUT))      w_state_next = ST_ERROR;
            end
            ST_ERROR:     w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    assign w_busy  = (r_state != ST_IDLE) && (r_state != ST_ERROR);
    assign w_start = (w_state_next == ST_RD_REQ) || (w_state_next == ST_WR_REQ);
    assign w_we    = (w_state_next == ST_WR_REQ);
    // PLL stays in reset from HOLD_RST through the last DRP write.
    assign w_hold_next = (w_state_next == ST_HOLD_RST) || (w_state_next == ST_RD_REQ)
                      || (w_state_next == ST_RD_WAIT)  || (w_state_next == ST_WR_REQ)
                      || (w_state_next == ST_WR_WAIT);

    always_ff @(posedge adc_clk_i) begin
        if (adc_rst_i) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_sel     <= 1'b0;
            r_idx     <= 1'b0;
            r_err     <= 1'b0;
            r_done    <= 1'b0;
            r_pll_rst <= 1'b1;
            r_dsp_rst <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_idx     <= w_idx_next;
            r_cnt     <= (w_state_next != r_state) ? 16'd0 : r_cnt + 16'd1;
            if (r_state == ST_IDLE && req_i) begin
                r_sel <= sel_i;
                r_err <= 1'b0;
            end else if (w_state_next == ST_ERROR) begin
                r_err <= 1'b1;
            end
            r_done    <= (r_state == ST_WAIT_LOCK) && pll_locked_i;
            r_pll_rst <= w_hold_next;
            r_dsp_rst <= w_busy | ~pll_locked_i;
        end
    end

    redpitaya_drp_access #(
        .DRDY_TIMEOUT (DRDY_TIMEOUT)
    ) u_drp_access (
        .i_clk       (adc_clk_i),
        .i_rst       (adc_rst_i),
        .i_start     (w_start),
        .i_we        (w_we),
        .i_addr      (entry_addr(w_idx_next)),
        .i_di        (entry_wdata(r_idx, r_sel, w_rdata)),
        .i_drp_do    (drp_do_i),
        .i_drp_drdy  (drp_drdy_i),
        .o_drp_daddr (drp_daddr_o),
        .o_drp_di    (drp_di_o),
        .o_drp_den   (drp_den_o),
        .o_drp_dwe   (drp_dwe_o),
        .o_done      (w_acc_done),
        .o_timeout   (w_acc_timeout),
        .o_rdata     (w_rdata)
    );

    assign pll_rst_o = r_pll_rst;
    assign busy_o    = w_busy;
    assign done_o    = r_done;
    assign err_o     = r_err;
    assign dsp_rst_o = r_dsp_rst;

endmodule

// File: tb/tb_redpitaya_pll_drp_ctrl.sv
// Directed bench for redpitaya_pll_drp_ctrl with a simple DRP/PLL responder.
module tb_redpitaya_pll_drp_ctrl;

    localparam int LOCK_T = 100;
    localparam int DRDY_T = 63;
    localparam int HOLD   = 15;
    localparam int LIM    = 400;

    logic        clk = 1'b0;
    logic        adc_rst_i;
    logic        req_i;
    logic        sel_i;
    logic        pll_locked_i;
    logic [15:0] drp_do_i = 16'h0;
    logic        drp_drdy_i = 1'b0;
    logic        pll_rst_o;
    logic [6:0]  drp_daddr_o;
    logic [15:0] drp_di_o;
    logic        drp_den_o;
    logic        drp_dwe_o;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic        dsp_rst_o;

    logic        drdy_en;
    logic [15:0] do_e;
    logic [15:0] do_f;

    int          n_checks = 0;
    int          n_errors = 0;

    // responder state
    int          den_cnt = 0;
    int          bad_proto = 0;
    int          cd = 0;
    logic        prev_den = 1'b0;
    logic [6:0]  pend_addr = 7'h0;
    logic [6:0]  wr_addr_q[$];
    logic [15:0] wr_data_q[$];
    logic [6:0]  rd_addr_q[$];

    always #5 clk = ~clk;

    redpitaya_pll_drp_ctrl #(
        .LOCK_TIMEOUT (LOCK_T),
        .DRDY_TIMEOUT (DRDY_T),
        .RST_HOLD     (HOLD)
    ) dut (
        .adc_clk_i    (clk),
        .adc_rst_i    (adc_rst_i),
        .req_i        (req_i),
        .sel_i        (sel_i),
        .pll_locked_i (pll_locked_i),
        .drp_do_i     (drp_do_i),
        .drp_drdy_i   (drp_drdy_i),
        .pll_rst_o    (pll_rst_o),
        .drp_daddr_o  (drp_daddr_o),
        .drp_di_o     (drp_di_o),
        .drp_den_o    (drp_den_o),
        .drp_dwe_o    (drp_dwe_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .err_o        (err_o),
        .dsp_rst_o    (dsp_rst_o)
    );

    // DRP model: DRDY three cycles after each DEN, read data chosen by address.
    always @(negedge clk) begin
        drp_drdy_i = 1'b0;
        if (cd > 0) begin
            cd = cd - 1;
            if (cd == 0 && drdy_en) begin
                drp_drdy_i = 1'b1;
                drp_do_i   = (pend_addr == 7'h0E) ? do_e : do_f;
            end
        end
        if (drp_den_o) begin
            den_cnt = den_cnt + 1;
            if (prev_den || cd > 0) bad_proto = bad_proto + 1;
            if (drp_dwe_o) begin
                wr_addr_q.push_back(drp_daddr_o);
                wr_data_q.push_back(drp_di_o);
            end else begin
                rd_addr_q.push_back(drp_daddr_o);
            end
            pend_addr = drp_daddr_o;
            cd = 3;
        end
        if (drp_dwe_o && !drp_den_o) bad_proto = bad_proto + 1;
        prev_den = drp_den_o;
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_req(input logic s);
        sel_i = s;
        req_i = 1'b1;
        @(negedge clk);
        req_i = 1'b0;
    endtask

    task automatic wait_release(output int k);
        k = 0;
        while (pll_rst_o && k < LIM) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic wait_done(output int k);
        k = 0;
        while (!done_o && k < LIM) begin
            @(negedge clk);
            k++;
        end
    endtask

    initial begin
        int k;
        int d0;
        int w0;
        int r0;

        adc_rst_i    = 1'b1;
        pll_locked_i = 1'b0;
        req_i        = 1'b0;
        sel_i        = 1'b0;
        drdy_en      = 1'b1;
        do_e         = 16'h0;
        do_f         = 16'h0;
        tick(2);

        check_eq("rst_pll_rst", 32'(pll_rst_o), 32'd1);
        check_eq("rst_den",     32'(drp_den_o), 32'd0);
        check_eq("rst_dwe",     32'(drp_dwe_o), 32'd0);
        check_eq("rst_busy",    32'(busy_o),    32'd0);
        check_eq("rst_done",    32'(done_o),    32'd0);
        check_eq("rst_err",     32'(err_o),     32'd0);
        check_eq("rst_dsp_rst", 32'(dsp_rst_o), 32'd1);
        check_eq("rst_daddr",   32'(drp_daddr_o), 32'd0);
        check_eq("rst_di",      32'(drp_di_o),  32'd0);
        adc_rst_i = 1'b0;
        tick(1);
        check_eq("idle_pll_rst", 32'(pll_rst_o), 32'd0);
        pll_locked_i = 1'b1;
        tick(2);
        check_eq("idle_dsp_rst", 32'(dsp_rst_o), 32'd0);

        // divide-by-2 sequence, with an extra request while busy
        do_e = 16'hA0C3;
        do_f = 16'h1480;
        d0 = den_cnt;
        w0 = wr_addr_q.size();
        r0 = rd_addr_q.size();
        pulse_req(1'b1);
        pll_locked_i = 1'b0;
        check_eq("t1_busy",    32'(busy_o),    32'd1);
        check_eq("t1_pll_rst", 32'(pll_rst_o), 32'd1);
        tick(3);
        pulse_req(1'b0);
        wait_release(k);
        check_eq("t1_release", 32'(pll_rst_o), 32'd0);
        tick(100);
        pll_locked_i = 1'b1;
        wait_done(k);
        check_eq("t1_done",      32'(done_o),    32'd1);
        check_eq("t1_busy_done", 32'(busy_o),    32'd0);
        check_eq("t1_dsp_rst_a", 32'(dsp_rst_o), 32'd1);
        tick(1);
        check_eq("t1_done_pulse", 32'(done_o),    32'd0);
        check_eq("t1_dsp_rst_b",  32'(dsp_rst_o), 32'd0);
        check_eq("t1_den_count", 32'(den_cnt - d0), 32'd4);
        check_eq("t1_wr_count",  32'(wr_addr_q.size() - w0), 32'd2);
        if (wr_addr_q.size() >= w0 + 2 && rd_addr_q.size() >= r0 + 2) begin
            check_eq("t1_rd0_addr", 32'(rd_addr_q[r0]),     32'h0E);
            check_eq("t1_rd1_addr", 32'(rd_addr_q[r0 + 1]), 32'h0F);
            check_eq("t1_wr0_addr", 32'(wr_addr_q[w0]),     32'h0E);
            check_eq("t1_wr0_data", 32'(wr_data_q[w0]),     32'hA041);
            check_eq("t1_wr1_addr", 32'(wr_addr_q[w0 + 1]), 32'h0F);
            check_eq("t1_wr1_data", 32'(wr_data_q[w0 + 1]), 32'h1400);
        end

        // divide-by-4 sequence, reset hold length
        do_e = 16'h0000;
        do_f = 16'h0000;
        w0 = wr_addr_q.size();
        pulse_req(1'b0);
        pll_locked_i = 1'b0;
        k = 0;
        while (!drp_den_o && k < 100) begin
            if (pll_rst_o) k++;
            @(negedge clk);
        end
        check_eq("t2_hold_cycles", 32'(k), 32'(HOLD + 1));
        wait_release(k);
        tick(10);
        pll_locked_i = 1'b1;
        wait_done(k);
        check_eq("t2_done", 32'(done_o), 32'd1);
        check_eq("t2_wr_count", 32'(wr_addr_q.size() - w0), 32'd2);
        if (wr_addr_q.size() >= w0 + 2) begin
            check_eq("t2_wr0_addr", 32'(wr_addr_q[w0]),     32'h0E);
            check_eq("t2_wr0_data", 32'(wr_data_q[w0]),     32'h0082);
            check_eq("t2_wr1_addr", 32'(wr_addr_q[w0 + 1]), 32'h0F);
            check_eq("t2_wr1_data", 32'(wr_data_q[w0 + 1]), 32'h0000);
        end
        tick(2);

        // DRDY never returned; k counts cycles from the DEN cycle
        drdy_en = 1'b0;
        d0 = den_cnt;
        pulse_req(1'b0);
        pll_locked_i = 1'b0;
        k = 0;
        while (!drp_den_o && k < LIM) begin
            @(negedge clk);
            k++;
        end
        k = 0;
        while (!err_o && k < LIM) begin
            @(negedge clk);
            k++;
        end
        check_eq("t3_drdy_timeout", 32'(k), 32'(DRDY_T + 2));
        check_eq("t3_err",     32'(err_o),     32'd1);
        check_eq("t3_pll_rst", 32'(pll_rst_o), 32'd0);
        check_eq("t3_busy",    32'(busy_o),    32'd0);
        tick(1);
        check_eq("t3_err_sticky", 32'(err_o), 32'd1);
        check_eq("t3_den_count",  32'(den_cnt - d0), 32'd1);
        drdy_en = 1'b1;
        tick(4);

        // lock never arrives; k counts cycles from the RELEASE cycle
        pulse_req(1'b0);
        check_eq("t4_err_clear", 32'(err_o), 32'd0);
        wait_release(k);
        k = 0;
        while (!err_o && k < LIM) begin
            @(negedge clk);
            k++;
        end
        check_eq("t4_lock_timeout", 32'(k), 32'(LOCK_T + 2));
        check_eq("t4_busy", 32'(busy_o), 32'd0);
        tick(1);

        // reset while a write is outstanding
        pulse_req(1'b1);
        check_eq("t5_err_clear", 32'(err_o), 32'd0);
        k = 0;
        while (!(drp_den_o && drp_dwe_o) && k < LIM) begin
            @(negedge clk);
            k++;
        end
        tick(1);
        d0 = den_cnt;
        adc_rst_i = 1'b1;
        tick(1);
        check_eq("t5_busy",    32'(busy_o),    32'd0);
        check_eq("t5_pll_rst", 32'(pll_rst_o), 32'd1);
        check_eq("t5_den",     32'(drp_den_o), 32'd0);
        check_eq("t5_dsp_rst", 32'(dsp_rst_o), 32'd1);
        adc_rst_i = 1'b0;
        tick(100);
        check_eq("t5_no_den",      32'(den_cnt - d0), 32'd0);
        check_eq("t5_busy_after",  32'(busy_o),       32'd0);
        check_eq("t5_pll_rst_off", 32'(pll_rst_o),    32'd0);
        check_eq("drp_protocol",   32'(bad_proto),    32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
